bk_pipelined_add_sub: RTL and testbench

//  Two-stage pipelined adder/subtractor built on the valence-2 Brent-Kung prefix tree, with valid/ready on both sides.

---
 rtl/bk_pipelined_add_sub.sv | 143 ++++++++++++++
 tb/tb_bk_pipelined_add_sub.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_pipelined_add_sub.sv
// Two-stage pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Stage 1 runs the prefix up-sweep; stage 2 finishes the down-sweep, forms the sum and the flags.
module bk_pipelined_add_sub #(
  parameter int N_BIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] operand_1,
  input  logic [N_BIT-1:0] operand_2,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  if (N_BIT < 4 || N_BIT > 64 || (N_BIT & (N_BIT - 1)) != 0) begin : g_bad_width
    $error("bk_pipelined_add_sub: N_BIT must be a power of two in 4..64");
  end

  logic [N_BIT-1:0] w_b_eff;
  logic             w_c0;
  logic [N_BIT-1:0] w_p_raw;
  logic [N_BIT-1:0] w_g_up;
  logic [N_BIT-1:0] w_p_up;
  logic [N_BIT-1:0] w_g_all;
  logic [N_BIT-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_s1_adv;
  logic             w_s2_adv;

  logic             r_s1_valid;
  logic [N_BIT-1:0] r_s1_g;
  logic [N_BIT-1:0] r_s1_p;
  logic [N_BIT-1:0] r_s1_p_raw;
  logic             r_s1_c0;
  logic             r_s1_sub;
  logic             r_s1_a_msb;
  logic             r_s1_b_msb;

  logic             r_s2_valid;
  logic [N_BIT-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // Handshake: a stage may load when it is empty or its contents move on this edge.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;

  // Operand conditioning and up-sweep; c0 is folded into g[0] so every prefix G is a carry.
  always_comb begin : up_sweep
    logic [N_BIT-1:0] g_v;
    logic [N_BIT-1:0] p_v;
    w_b_eff = op_sub ? ~operand_2 : operand_2;
    w_c0    = op_sub ? ~cin : cin;
    w_p_raw = operand_1 ^ w_b_eff;
    p_v     = w_p_raw;
    g_v     = operand_1 & w_b_eff;
    g_v[0]  = g_v[0] | (p_v[0] & w_c0);
    for (int s = 32'sd2; s <= N_BIT; s = s * 32'sd2) begin
      for (int i = s - 32'sd1; i < N_BIT; i = i + s) begin
        g_v[i] = g_v[i] | (p_v[i] & g_v[i - s / 32'sd2]);
        p_v[i] = p_v[i] & p_v[i - s / 32'sd2];
      end
    end
    w_g_up = g_v;
    w_p_up = p_v;
  end

  // Down-sweep fills the remaining prefix positions, then sum and flags.
  always_comb begin : down_sweep
    logic [N_BIT-1:0] g_v;
    g_v = r_s1_g;
    for (int s = N_BIT / 32'sd2; s >= 32'sd2; s = s / 32'sd2) begin
      for (int i = s + s / 32'sd2 - 32'sd1; i < N_BIT; i = i + s) begin
        g_v[i] = g_v[i] | (r_s1_p[i] & g_v[i - s / 32'sd2]);
      end
    end
    w_g_all = g_v;
    w_sum   = r_s1_p_raw ^ {w_g_all[N_BIT-2:0], r_s1_c0};
    w_cout  = r_s1_sub ? ~w_g_all[N_BIT-1] : w_g_all[N_BIT-1];
    w_ovf   = (r_s1_a_msb == r_s1_b_msb) && (w_sum[N_BIT-1] != r_s1_a_msb);
  end

  // Stage 1 register: payload captured only on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_g     <= '0;
      r_s1_p     <= '0;
      r_s1_p_raw <= '0;
      r_s1_c0    <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_g     <= w_g_up;
        r_s1_p     <= w_p_up;
        r_s1_p_raw <= w_p_raw;
        r_s1_c0    <= w_c0;
        r_s1_sub   <= op_sub;
        r_s1_a_msb <= operand_1[N_BIT-1];
        r_s1_b_msb <= w_b_eff[N_BIT-1];
      end
    end
  end

  // Stage 2 register: outputs hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_sum;
        r_cout   <= w_cout;
        r_ovf    <= w_ovf;
        r_zero   <= (w_sum == '0);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_bk_pipelined_add_sub.sv
// Bench for bk_pipelined_add_sub: four widths share one stimulus stream and one in-order
// scoreboard; expected values come from a plain-arithmetic model.
module tb_bk_pipelined_add_sub;

  localparam int NW = 4;
  localparam int K32 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        op_sub;
  logic        cin;
  logic        out_ready;
  logic [63:0] opa;
  logic [63:0] opb;

  logic        in_ready_w  [NW];
  logic        out_valid_w [NW];
  logic [63:0] res_w       [NW];
  logic        cout_w      [NW];
  logic        ovf_w       [NW];
  logic        zero_w      [NW];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        c;
  } txn_t;

  txn_t q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_popped = 0;
  int n_unexpected = 0;

  function automatic int width_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : (k == 2) ? 32 : 64;
  endfunction

  for (genvar k = 0; k < NW; k++) begin : g_dut
    localparam int W = (k == 0) ? 4 : (k == 1) ? 16 : (k == 2) ? 32 : 64;
    logic         rdy;
    logic         vld;
    logic         co;
    logic         ov;
    logic         zr;
    logic [W-1:0] res;
    bk_pipelined_add_sub #(.N_BIT(W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
      .operand_1(opa[W-1:0]), .operand_2(opb[W-1:0]), .op_sub(op_sub), .cin(cin),
      .out_valid(vld), .out_ready(out_ready), .result(res), .cout(co),
      .overflow(ov), .zero(zr)
    );
    assign in_ready_w[k]  = rdy;
    assign out_valid_w[k] = vld;
    assign res_w[k]       = 64'(res);
    assign cout_w[k]      = co;
    assign ovf_w[k]       = ov;
    assign zero_w[k]      = zr;
  end

  // Reference: {result, carry/borrow, signed overflow, zero} from plain wide arithmetic.
  function automatic logic [66:0] ref_op(input int w, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input logic sub, input logic c);
    logic [64:0] mask, a, b, full;
    logic signed [66:0] sa, sb, sr, cx, maxp, minn;
    logic [63:0] res;
    logic co, ov;
    mask = (65'd1 << w) - 65'd1;
    a = {1'b0, a_in} & mask;
    b = {1'b0, b_in} & mask;
    if (sub) begin
      full = a - b - {64'd0, c};
      co = (a < (b + {64'd0, c}));
    end else begin
      full = a + b + {64'd0, c};
      co = full[w];
    end
    res = full[63:0] & mask[63:0];
    sa = {2'b00, a};
    sb = {2'b00, b};
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    cx = {66'd0, c};
    sr = sub ? (sa - sb - cx) : (sa + sb + cx);
    maxp = (67'sd1 <<< (w - 1)) - 67'sd1;
    minn = -(67'sd1 <<< (w - 1));
    ov = (sr > maxp) || (sr < minn);
    return {res, co, ov, (res == 64'd0)};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: push on input transfer, compare the head whenever a result is offered.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid_w[K32]) begin
        if (q.size() == 0) begin
          n_unexpected++;
        end else begin
          for (int k = 0; k < NW; k++) begin
            check_eq($sformatf("out_w%0d", width_of(k)),
                     {out_valid_w[k], res_w[k], cout_w[k], ovf_w[k], zero_w[k]},
                     {1'b1, ref_op(width_of(k), q[0].a, q[0].b, q[0].sub, q[0].c)});
          end
          if (out_ready) begin
            void'(q.pop_front());
            n_popped++;
          end
        end
      end
      if (in_valid && in_ready_w[K32]) q.push_back('{opa, opb, op_sub, cin});
    end
  end

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < NW; k++) begin
      check_eq($sformatf("%s_w%0d", tag, width_of(k)),
               {in_ready_w[k], out_valid_w[k], res_w[k], cout_w[k], ovf_w[k], zero_w[k]}, '0);
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic c, input logic [31:0] er,
                          input logic eco, input logic eov, input logic ezr);
    @(posedge clk); #1;
    opa = {32'($urandom), a};
    opb = {32'($urandom), b};
    op_sub = sub; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready_w[K32], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat1"}, out_valid_w[K32], 0);
    @(negedge clk);
    check_eq({tag, "_res"},
             {out_valid_w[K32], res_w[K32][31:0], cout_w[K32], ovf_w[K32], zero_w[K32]},
             {1'b1, er, eco, eov, ezr});
  endtask

  task automatic new_payload();
    int cat;
    cat = $urandom_range(0, 7);
    opa = {$urandom, $urandom};
    opb = {$urandom, $urandom};
    if (cat == 6) opa = 64'($urandom_range(0, 3));
    if (cat == 7) opb = -64'($urandom_range(0, 3));
    op_sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  initial begin
    int sent;
    int popped0;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    directed("sub_bin", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Backpressure: 8 ops streamed, consumer stalls for cycles 3..6.
    @(posedge clk);
    popped0 = n_popped;
    sent = 0; acc = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (acc) new_payload();
      in_valid = (sent < 8);
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        check_eq($sformatf("bp_in_ready_low_c%0d", c), in_ready_w[K32], 0);
        check_eq($sformatf("bp_out_held_c%0d", c), out_valid_w[K32], 1);
      end
      acc = in_valid && in_ready_w[K32];
      if (acc) sent++;
    end
    check_eq("bp_all_out", n_popped - popped0, 8);
    check_eq("bp_drained", q.size(), 0);

    // Reset with two ops in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; new_payload();
    @(negedge clk);
    check_eq("rst_acc0", in_ready_w[K32], 1);
    @(posedge clk); #1;
    new_payload();
    @(negedge clk);
    check_eq("rst_acc1", in_ready_w[K32], 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready_w[K32], 0);
    @(negedge clk);
    check_idle_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("rst_no_ghost_c%0d", c), out_valid_w[K32], 0);
    end
    directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    // Random traffic with random valid/ready.
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (acc || !in_valid) new_payload();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready_w[K32];
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check_eq("rand_drained", q.size(), 0);
    check_eq("no_unexpected", n_unexpected, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
